// File: rtl/aes256_uart_pkg.sv
// Shared constants and types for the UART-attached AES-256 block.
// Imported by the top level and its serial front end.
package aes256_uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 87;
    localparam int FRAME_BYTES = 48;
    localparam int RESULT_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        SEND = 2'd2
    } state_e;

endpackage

// File: rtl/aes256_uart_if.sv
// Board-side pin bundle: serial RX/TX lines and status LEDs.
// The board (or bench) is the master, the encryption block the slave.
interface aes256_uart_if;

    logic       data_in;
    logic       data_out;
    logic [7:0] led;

    modport master (
        output data_in,
        input  data_out,
        input  led
    );

    modport slave (
        input  data_in,
        output data_out,
        output led
    );

endinterface

// File: rtl/aes256_core.sv
// Iterative AES-256 encryptor: one round per cycle, keys expanded on the fly.
// Blocks and keys use FIPS-197 byte order (bits [127:120] = state byte 0).
module aes256_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key,
    input  logic [127:0] block_in,
    output logic         done,
    output logic [127:0] block_out
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[3'(i)]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t;
        logic [7:0] r;
        t = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            t = gmul(t, t);
            r = gmul(r, t);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
                 ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [255:0] expand(input logic [255:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
        logic [31:0] n0, n1, n2, n3, n4, n5, n6, n7;
        {w0, w1, w2, w3, w4, w5, w6, w7} = k;
        n0 = w0 ^ sub_word({w7[23:0], w7[31:24]}) ^ {rc, 24'h0};
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        n4 = w4 ^ sub_word(n3);
        n5 = w5 ^ n4;
        n6 = w6 ^ n5;
        n7 = w7 ^ n6;
        return {n0, n1, n2, n3, n4, n5, n6, n7};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s,
                                               input logic [127:0] rk,
                                               input logic last);
        logic [7:0] b [16];
        logic [7:0] h [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        o = '0;
        for (int n = 0; n < 16; n++)
            b[4'(n)] = sbox(s[7'(120 - 8 * n) +: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                h[4'(4 * c + r)] = b[4'(4 * ((c + r) % 4) + r)];
        for (int c = 0; c < 4; c++) begin
            a0 = h[4'(4 * c)];
            a1 = h[4'(4 * c + 1)];
            a2 = h[4'(4 * c + 2)];
            a3 = h[4'(4 * c + 3)];
            if (last)
                o[7'(96 - 32 * c) +: 32] = {a0, a1, a2, a3};
            else
                o[7'(96 - 32 * c) +: 32] = {
                    xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                    a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                    a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                    xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
                };
        end
        return o ^ rk;
    endfunction

    logic [127:0] st;
    logic [255:0] kw;
    logic [3:0]   rnd;
    logic [7:0]   rcon;
    logic         busy;
    logic [127:0] nxt;

    // Odd rounds use the low half of the 8-word key window, even the high half
    assign nxt = aes_round(st, rnd[0] ? kw[127:0] : kw[255:128], rnd == 4'd14);

    // Round sequencer: initial AddRoundKey on start, then rounds 1..14
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            rnd  <= '0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                st <= nxt;
                if (rnd[0]) begin
                    kw   <= expand(kw, rcon);
                    rcon <= xtime(rcon);
                end
                if (rnd == 4'd14) begin
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    block_out <= nxt;
                end else begin
                    rnd <= rnd + 1'b1;
                end
            end else if (start) begin
                st   <= block_in ^ key[255:128];
                kw   <= key;
                rnd  <= 4'd1;
                rcon <= 8'h01;
                busy <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with a two-flop synchronizer.
// Emits a one-cycle rx_valid per byte whose stop bit is good.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    logic          s1, s2, s3;
    logic [1:0]    st;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;

    // Synchronize the line and keep one older sample for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= rx;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Bit-timing state machine sampling at each bit centre
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= R_IDLE;
            cnt      <= '0;
            idx      <= '0;
            shift    <= '0;
            rx_valid <= 1'b0;
            rx_byte  <= '0;
        end else begin
            rx_valid <= 1'b0;
            case (st)
                R_IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (s3 && !s2) st <= R_START;
                end
                R_START: begin
                    if (cnt == HALF) begin
                        cnt <= '0;
                        st  <= s2 ? R_IDLE : R_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt == FULL) begin
                        cnt   <= '0;
                        shift <= {s2, shift[7:1]};
                        idx   <= idx + 1'b1;
                        if (idx == 3'd7) st <= R_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (cnt == FULL) begin
                        cnt <= '0;
                        st  <= R_IDLE;
                        if (s2) begin
                            rx_valid <= 1'b1;
                            rx_byte  <= shift;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: st <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter; line driven straight from a flop.
// busy covers the whole frame through the end of the stop bit.
module uart_tx_core #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    logic [9:0]    sh;
    logic [CW-1:0] cnt;
    logic [3:0]    bitn;

    // Shift out start, data, stop; ones refill so the idle line stays high
    always_ff @(posedge clk) begin
        if (rst) begin
            sh      <= '1;
            cnt     <= '0;
            bitn    <= '0;
            tx_busy <= 1'b0;
        end else if (!tx_busy) begin
            if (tx_start) begin
                sh      <= {1'b1, tx_data, 1'b0};
                cnt     <= '0;
                bitn    <= '0;
                tx_busy <= 1'b1;
            end
        end else if (cnt == FULL) begin
            cnt <= '0;
            sh  <= {1'b1, sh[9:1]};
            if (bitn == 4'd9) tx_busy <= 1'b0;
            else bitn <= bitn + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tx = sh[0];

endmodule

// File: rtl/aes256_uart_top.sv
// Serial front end for AES-256: 48-byte key+plaintext frames in,
// 16-byte ciphertext out, LEDs count completed result frames.
module aes256_uart_top
    import aes256_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    aes256_uart_if.slave pins
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_ENC  = ENC;
    localparam logic [1:0] S_SEND = SEND;
    localparam logic [5:0] LAST_BYTE = 6'(FRAME_BYTES - 1);
    localparam logic [4:0] RES_END = 5'(RESULT_BYTES);

    logic         rx_valid;
    logic [7:0]   rx_byte;
    logic [5:0]   byte_cnt;
    logic [383:0] buffer;
    logic         frame_ready;
    logic         take;
    logic [1:0]   state;
    logic [255:0] key_op;
    logic [127:0] pt_op;
    logic [127:0] result;
    logic [127:0] aes_out;
    logic         aes_start;
    logic         aes_done;
    logic [4:0]   tx_idx;
    logic         tx_start;
    logic         tx_busy;
    logic [7:0]   tx_data;
    logic         tx_line;
    logic [7:0]   led_cnt;

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (pins.data_in),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte)
    );

    uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx       (tx_line),
        .tx_busy  (tx_busy)
    );

    aes256_core u_aes (
        .clk       (clk),
        .rst       (rst),
        .start     (aes_start),
        .key       (key_op),
        .block_in  (pt_op),
        .done      (aes_done),
        .block_out (aes_out)
    );

    assign take     = (state == S_IDLE) && frame_ready;
    assign tx_start = (state == S_SEND) && !tx_busy && (tx_idx != RES_END);
    assign tx_data  = result[{tx_idx[3:0], 3'b000} +: 8];

    assign pins.data_out = tx_line;
    assign pins.led      = led_cnt;

    // Frame assembly; a frame completing this cycle outranks the take-clear
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt    <= '0;
            frame_ready <= 1'b0;
        end else begin
            if (take) frame_ready <= 1'b0;
            if (rx_valid) begin
                buffer[{byte_cnt, 3'b000} +: 8] <= rx_byte;
                if (byte_cnt == LAST_BYTE) begin
                    byte_cnt    <= '0;
                    frame_ready <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
        end
    end

    // Control: snapshot operands, run the core, stream the result out
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            aes_start <= 1'b0;
            tx_idx    <= '0;
            led_cnt   <= '0;
        end else begin
            aes_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (take) begin
                        key_op    <= buffer[255:0];
                        pt_op     <= buffer[383:256];
                        aes_start <= 1'b1;
                        state     <= S_ENC;
                    end
                end
                S_ENC: begin
                    if (aes_done) begin
                        result <= aes_out;
                        tx_idx <= '0;
                        state  <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (tx_start) begin
                        tx_idx <= tx_idx + 1'b1;
                    end else if (tx_idx == RES_END && !tx_busy) begin
                        led_cnt <= led_cnt + 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes256_uart_top.sv
// Scoreboard bench: frames are driven serially, expected ciphertext bytes
// are queued, and a UART monitor on data_out pops and compares them.
module tb_aes256_uart_top;

    localparam int CPB = 8;
    localparam logic [127:0] PT = 128'h014730f80ac625fe84f026c60bfd547d;
    localparam logic [127:0] CT = 128'h5c9d844ed46f9885085e5d6a4f94c7d7;

    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;
    int rx_count = 0;
    logic [7:0] exp_q[$];
    logic [127:0] pt_v = PT;
    logic [127:0] ct_v = CT;

    aes256_uart_if bus();

    aes256_uart_top #(.CLKS_PER_BIT(CPB)) dut (
        .clk  (clk),
        .rst  (rst),
        .pins (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.data_in = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[3'(i)]);
        send_bit(stop);
    endtask

    // Zero key then plaintext LSB byte first; optional bad byte before index bad_at
    task automatic send_frame(input int bad_at);
        logic [7:0] d;
        for (int i = 0; i < 16; i++) exp_q.push_back(ct_v[7'(8 * i) +: 8]);
        for (int k = 0; k < 48; k++) begin
            if (k == bad_at) begin
                send_byte(8'hA5, 1'b0);
                send_bit(1'b1);
                send_bit(1'b1);
            end
            d = (k < 32) ? 8'h00 : pt_v[7'(8 * (k - 32)) +: 8];
            send_byte(d, 1'b1);
        end
        send_bit(1'b1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check({"drain_", name}, exp_q.size(), 0);
        repeat (2 * CPB) @(negedge clk);
    endtask

    // Monitor: decode each byte on data_out and compare against the queue
    initial begin
        logic prev;
        logic [7:0] b;
        logic [7:0] e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !bus.data_out && !rst) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[3'(i)] = bus.data_out;
                end
                repeat (CPB) @(negedge clk);
                check("tx_stop_bit", 32'(bus.data_out), 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected_byte actual=%02h expected=none", b);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", 32'(b), 32'(e));
                end
                rx_count++;
            end
            prev = bus.data_out;
        end
    end

    initial begin
        int lows;
        int badled;
        int base;
        int n;
        rst = 1'b1;
        bus.data_in = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_dout", 32'(bus.data_out), 1);
        check("reset_led", 32'(bus.led), 0);
        rst = 1'b0;

        lows = 0;
        badled = 0;
        repeat (10000) begin
            @(negedge clk);
            if (bus.data_out !== 1'b1) lows++;
            if (bus.led !== 8'd0) badled++;
        end
        check("idle_dout_lows", lows, 0);
        check("idle_led_changes", badled, 0);

        send_frame(-1);
        wait_drain("kat");
        check("kat_led", 32'(bus.led), 1);

        send_frame(-1);
        wait_drain("repeat");
        check("repeat_led", 32'(bus.led), 2);
        check("repeat_total_bytes", rx_count, 32);

        send_frame(20);
        wait_drain("framing");
        check("framing_led", 32'(bus.led), 3);

        send_frame(-1);
        send_frame(-1);
        wait_drain("b2b");
        check("b2b_led", 32'(bus.led), 5);
        check("b2b_total_bytes", rx_count, 80);

        base = rx_count;
        send_frame(-1);
        n = 0;
        while (rx_count < base + 5 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("midsend_bytes_before_rst", rx_count - base, 5);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midsend_rst_dout", 32'(bus.data_out), 1);
        @(negedge clk);
        rst = 1'b0;
        check("midsend_rst_led", 32'(bus.led), 0);
        lows = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bus.data_out !== 1'b1) lows++;
        end
        check("midsend_quiet_lows", lows, 0);
        check("midsend_no_more_bytes", rx_count - base, 5);

        send_frame(-1);
        wait_drain("fresh");
        check("fresh_led", 32'(bus.led), 1);
        check("fresh_bytes", rx_count - base, 21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
